// File: rtl/stream_width_convert_if.sv
// Valid/ready bundle for stream_width_convert: input beat, converted output beat
// and the saturation event counter with its clear strobe.
interface stream_width_convert_if #(
   parameter int NUM_INPUTS  = 16,
   parameter int NUM_OUTPUTS = 32,
   parameter int NUM_LANES   = 1
);
   logic                             in_valid;
   logic                             in_ready;
   logic [NUM_LANES*NUM_INPUTS-1:0]  in_data;
   logic                             in_signed;
   logic                             out_valid;
   logic                             out_ready;
   logic [NUM_LANES*NUM_OUTPUTS-1:0] out_data;
   logic [NUM_LANES-1:0]             out_sat;
   logic                             sat_clr;
   logic [15:0]                      sat_count;

   // master drives the input beat and consumes the output beat
   modport master (
      output in_valid, in_data, in_signed, out_ready, sat_clr,
      input  in_ready, out_valid, out_data, out_sat, sat_count
   );

   modport slave (
      input  in_valid, in_data, in_signed, out_ready, sat_clr,
      output in_ready, out_valid, out_data, out_sat, sat_count
   );
endinterface

// File: rtl/stream_width_convert.sv
// Multi-lane word width converter (extend / saturate / pass) behind a registered
// valid/ready stage with a one-beat skid so in_ready never depends on out_ready.
module stream_width_convert #(
   parameter int NUM_INPUTS  = 16,
   parameter int NUM_OUTPUTS = 32,
   parameter int NUM_LANES   = 1
) (
   input logic                   clk,
   input logic                   rst,
   stream_width_convert_if.slave bus
);
   localparam int NI = NUM_INPUTS;
   localparam int NO = NUM_OUTPUTS;
   localparam int DW = NUM_LANES * NO;

   logic [DW-1:0]        conv_data;
   logic [NUM_LANES-1:0] conv_sat;

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [NI-1:0] x;
      assign x = bus.in_data[gi*NI +: NI];

      if (NO > NI) begin : g_widen
         assign conv_data[gi*NO +: NO] = {{(NO-NI){bus.in_signed & x[NI-1]}}, x};
         assign conv_sat[gi]           = 1'b0;
      end else if (NO == NI) begin : g_pass
         assign conv_data[gi*NO +: NO] = x;
         assign conv_sat[gi]           = 1'b0;
      end else begin : g_narrow
         logic          sgn_ovf;
         logic          uns_ovf;
         logic [NO-1:0] clamp;
         // a signed value fits only if every bit from NO-1 upward agrees
         assign sgn_ovf = (x[NI-1:NO-1] != '0) && (x[NI-1:NO-1] != '1);
         assign uns_ovf = |x[NI-1:NO];
         always_comb begin
            clamp = x[NO-1:0];
            if (bus.in_signed && sgn_ovf) begin
               clamp = {x[NI-1], {(NO-1){!x[NI-1]}}};
            end else if (!bus.in_signed && uns_ovf) begin
               clamp = '1;
            end
         end
         assign conv_data[gi*NO +: NO] = clamp;
         assign conv_sat[gi]           = bus.in_signed ? sgn_ovf : uns_ovf;
      end
   end

   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [DW-1:0]        out_data_q, out_data_d;
   logic [NUM_LANES-1:0] out_sat_q, out_sat_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [DW-1:0]        skid_data_q, skid_data_d;
   logic [NUM_LANES-1:0] skid_sat_q, skid_sat_d;
   logic [15:0]          sat_count_q, sat_count_d;
   logic [16:0]          sat_pop;
   logic [16:0]          sat_sum;
   logic                 accept;
   logic                 out_xfer;
   logic                 out_free;

   assign accept   = bus.in_valid && in_ready_q;
   assign out_xfer = out_valid_q && bus.out_ready;
   assign out_free = !out_valid_q || bus.out_ready;

   // in_ready_q == !skid_valid_q, so an accept never coincides with a full skid
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sat_d    = out_sat_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_sat_d   = skid_sat_q;
      if (out_free) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_sat_d    = skid_sat_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = conv_data;
            out_sat_d   = conv_sat;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = conv_data;
         skid_sat_d   = conv_sat;
      end
      in_ready_d = !skid_valid_d;
   end

   always_comb begin
      sat_pop = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         sat_pop = sat_pop + 17'(out_sat_q[k]);
      end
      sat_sum     = {1'b0, sat_count_q} + sat_pop;
      sat_count_d = sat_count_q;
      if (bus.sat_clr) begin
         sat_count_d = '0;
      end else if (out_xfer) begin
         sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sat_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_sat_q   <= '0;
         sat_count_q  <= '0;
      end else begin
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sat_q    <= out_sat_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_sat_q   <= skid_sat_d;
         sat_count_q  <= sat_count_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.sat_count = sat_count_q;
endmodule

// File: tb/tb_stream_width_convert.sv
// Bench for stream_width_convert: 16->32 x1, 16->8 x4 and 16->16 x1 instances,
// vector table, randomized stream against a queue model, saturation counter and reset.
module tb_stream_width_convert;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stream_width_convert_if #(.NUM_INPUTS(16), .NUM_OUTPUTS(32), .NUM_LANES(1)) w_if ();
   stream_width_convert_if #(.NUM_INPUTS(16), .NUM_OUTPUTS(8),  .NUM_LANES(4)) n_if ();
   stream_width_convert_if #(.NUM_INPUTS(16), .NUM_OUTPUTS(16), .NUM_LANES(1)) e_if ();

   stream_width_convert #(.NUM_INPUTS(16), .NUM_OUTPUTS(32), .NUM_LANES(1)) u_wide (
      .clk(clk), .rst(rst), .bus(w_if));
   stream_width_convert #(.NUM_INPUTS(16), .NUM_OUTPUTS(8), .NUM_LANES(4)) u_narrow (
      .clk(clk), .rst(rst), .bus(n_if));
   stream_width_convert #(.NUM_INPUTS(16), .NUM_OUTPUTS(16), .NUM_LANES(1)) u_equal (
      .clk(clk), .rst(rst), .bus(e_if));

   typedef struct {
      int          inst;
      logic [15:0] din;
      bit          sg;
      logic [31:0] exp_d;
      bit          exp_s;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
   } beat_t;

   int          checks = 0;
   int          errors = 0;
   vec_t        vecs[16];
   beat_t       exp_q[$];
   int          exp_cnt;
   bit          held_prev;
   bit          pending;
   bit          verbose;
   logic [31:0] held_d;
   logic [3:0]  held_s;
   logic [63:0] drv_d;
   bit          drv_sg;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: interpret the lane as an integer, clamp to the output range.
   function automatic void conv_lane(input logic [15:0] x, input bit sg, input int no,
                                     output logic [31:0] y, output bit s);
      longint v, lo, hi, one;
      one = 1;
      v = sg ? longint'($signed(x)) : longint'({48'h0, x});
      if (sg) begin
         lo = -(one << (no - 1));
         hi = (one << (no - 1)) - 1;
      end else begin
         lo = 0;
         hi = (one << no) - 1;
      end
      s = 1'b0;
      if (v > hi) begin
         v = hi;
         s = 1'b1;
      end else if (v < lo) begin
         v = lo;
         s = 1'b1;
      end
      y = 32'(v);
   endfunction

   function automatic beat_t model_beat(input logic [63:0] d, input bit sg);
      beat_t       b;
      logic [31:0] y;
      bit          s;
      b.d = '0;
      b.s = '0;
      for (int k = 0; k < 4; k++) begin
         conv_lane(d[k*16 +: 16], sg, 8, y, s);
         b.d[k*8 +: 8] = y[7:0];
         b.s[k]        = s;
      end
      return b;
   endfunction

   function automatic logic [63:0] rand_beat();
      logic [63:0] r;
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(0, 1) == 1) r[k*16 +: 16] = 16'($urandom_range(0, 255)) - 16'd128;
         else                           r[k*16 +: 16] = 16'($urandom);
      end
      return r;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      logic        ir, ov;
      logic [31:0] od;
      logic [3:0]  os;
      @(negedge clk);
      ir = 1'b0;
      case (v.inst)
         0: begin
            ir = w_if.in_ready;
            w_if.in_valid = 1'b1; w_if.in_data = v.din; w_if.in_signed = v.sg;
         end
         1: begin
            ir = n_if.in_ready;
            n_if.in_valid = 1'b1; n_if.in_data = {48'h0, v.din}; n_if.in_signed = v.sg;
         end
         default: begin
            ir = e_if.in_ready;
            e_if.in_valid = 1'b1; e_if.in_data = v.din; e_if.in_signed = v.sg;
         end
      endcase
      chk("vec_in_ready", 64'(ir), 64'(1));
      @(negedge clk);
      case (v.inst)
         0: begin ov = w_if.out_valid; od = w_if.out_data; os = {3'b0, w_if.out_sat}; w_if.in_valid = 1'b0; end
         1: begin ov = n_if.out_valid; od = {24'h0, n_if.out_data[7:0]}; os = n_if.out_sat; n_if.in_valid = 1'b0; end
         default: begin ov = e_if.out_valid; od = {16'h0, e_if.out_data}; os = {3'b0, e_if.out_sat}; e_if.in_valid = 1'b0; end
      endcase
      chk("vec_latency_valid", 64'(ov), 64'(1));
      chk("vec_data", 64'(od), 64'(v.exp_d));
      chk("vec_sat", 64'(os), 64'({3'b0, v.exp_s}));
      $display("vec %0d inst=%0d in=%h signed=%0d out=%h sat=%b", idx, v.inst, v.din, v.sg, od, os);
      @(negedge clk);
      case (v.inst)
         0:       ov = w_if.out_valid;
         1:       ov = n_if.out_valid;
         default: ov = e_if.out_valid;
      endcase
      chk("vec_drained", 64'(ov), 64'(0));
   endtask

   // One clock of the 4-lane stream, checked against the queue model.
   task automatic step(input bit iv_in, input logic [63:0] d_in, input bit sg_in,
                       input bit ordy, input bit clr);
      bit          iv, sg;
      logic [63:0] d;
      beat_t       b;
      iv = iv_in; d = d_in; sg = sg_in;
      @(negedge clk);
      chk("out_valid_occupancy", 64'(n_if.out_valid), 64'(exp_q.size() > 0));
      chk("in_ready_occupancy", 64'(n_if.in_ready), 64'(exp_q.size() < 2));
      chk("sat_count", 64'(n_if.sat_count), 64'(exp_cnt));
      if (held_prev) begin
         chk("stall_data_stable", 64'(n_if.out_data), 64'(held_d));
         chk("stall_sat_stable", 64'(n_if.out_sat), 64'(held_s));
      end
      if (pending) begin
         iv = 1'b1; d = drv_d; sg = drv_sg;
      end
      n_if.in_valid  = iv;
      n_if.in_data   = d;
      n_if.in_signed = sg;
      n_if.out_ready = ordy;
      n_if.sat_clr   = clr;
      if (n_if.out_valid && ordy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%h required=none", n_if.out_data);
         end else begin
            b = exp_q.pop_front();
            chk("beat_data", 64'(n_if.out_data), 64'(b.d));
            chk("beat_sat", 64'(n_if.out_sat), 64'(b.s));
            exp_cnt += $countones(b.s);
            if (verbose) $display("beat out=%h sat=%b", n_if.out_data, n_if.out_sat);
         end
      end
      if (clr) exp_cnt = 0;
      if (exp_cnt > 65535) exp_cnt = 65535;
      if (iv && n_if.in_ready) exp_q.push_back(model_beat(d, sg));
      held_prev = n_if.out_valid && !ordy;
      held_d    = n_if.out_data;
      held_s    = n_if.out_sat;
      pending   = iv && !n_if.in_ready;
      drv_d     = d;
      drv_sg    = sg;
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_cnt   = 0;
      held_prev = 1'b0;
      pending   = 1'b0;
   endtask

   initial begin
      logic [63:0] four_sat;
      logic [63:0] two_sat;
      four_sat = {4{16'h0100}};
      two_sat  = {16'h0000, 16'h0005, 16'h0100, 16'hFF00};

      vecs[0]  = '{0, 16'h8001, 1'b1, 32'hFFFF8001, 1'b0};
      vecs[1]  = '{0, 16'h8001, 1'b0, 32'h00008001, 1'b0};
      vecs[2]  = '{0, 16'h7FFF, 1'b1, 32'h00007FFF, 1'b0};
      vecs[3]  = '{0, 16'hFFFF, 1'b0, 32'h0000FFFF, 1'b0};
      vecs[4]  = '{1, 16'h0100, 1'b1, 32'h0000007F, 1'b1};
      vecs[5]  = '{1, 16'hFF00, 1'b1, 32'h00000080, 1'b1};
      vecs[6]  = '{1, 16'hFFF0, 1'b1, 32'h000000F0, 1'b0};
      vecs[7]  = '{1, 16'h0100, 1'b0, 32'h000000FF, 1'b1};
      vecs[8]  = '{1, 16'h00AB, 1'b0, 32'h000000AB, 1'b0};
      vecs[9]  = '{1, 16'h007F, 1'b1, 32'h0000007F, 1'b0};
      vecs[10] = '{1, 16'h0080, 1'b1, 32'h0000007F, 1'b1};
      vecs[11] = '{1, 16'hFF80, 1'b1, 32'h00000080, 1'b0};
      vecs[12] = '{1, 16'hFF7F, 1'b1, 32'h00000080, 1'b1};
      vecs[13] = '{1, 16'h00FF, 1'b0, 32'h000000FF, 1'b0};
      vecs[14] = '{2, 16'h8001, 1'b1, 32'h00008001, 1'b0};
      vecs[15] = '{2, 16'hFFFF, 1'b0, 32'h0000FFFF, 1'b0};

      w_if.in_valid = 1'b0; w_if.in_data = '0; w_if.in_signed = 1'b0; w_if.out_ready = 1'b1; w_if.sat_clr = 1'b0;
      n_if.in_valid = 1'b0; n_if.in_data = '0; n_if.in_signed = 1'b0; n_if.out_ready = 1'b1; n_if.sat_clr = 1'b0;
      e_if.in_valid = 1'b0; e_if.in_data = '0; e_if.in_signed = 1'b0; e_if.out_ready = 1'b1; e_if.sat_clr = 1'b0;
      verbose = 1'b1;
      clear_model();
      drv_d  = '0;
      drv_sg = 1'b0;

      // reset state, then in_ready one cycle after release
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(n_if.in_ready), 64'(0));
      chk("rst_out_valid", 64'(n_if.out_valid), 64'(0));
      chk("rst_out_data", 64'(n_if.out_data), 64'(0));
      chk("rst_out_sat", 64'(n_if.out_sat), 64'(0));
      chk("rst_sat_count", 64'(n_if.sat_count), 64'(0));
      chk("rst_wide_out_valid", 64'(w_if.out_valid), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(w_if.in_ready), 64'(1));

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_model();

      // randomized stream with a forced 3-cycle stall mid-burst
      for (int i = 0; i < 300; i++) begin
         bit iv, ordy, clr;
         iv   = (i >= 18 && i < 24) ? 1'b1 : ($urandom_range(0, 9) < 7);
         ordy = (i >= 20 && i < 23) ? 1'b0 : ($urandom_range(0, 4) != 0);
         clr  = ($urandom_range(0, 49) == 0);
         step(iv, rand_beat(), 1'($urandom_range(0, 1)), ordy, clr);
      end

      // saturation counter: climb to FFFE then stick at FFFF
      verbose = 1'b0;
      repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("sat_count_cleared", 64'(n_if.sat_count), 64'(0));
      for (int i = 0; i < 16383; i++) step(1'b1, four_sat, 1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, two_sat, 1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("sat_count_sticky", 64'(n_if.sat_count), 64'(16'hFFFF));
      $display("sat_count reached %h", n_if.sat_count);

      // clear wins over a concurrent saturating transfer
      step(1'b1, two_sat, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("sat_clr_with_xfer", 64'(n_if.sat_count), 64'(0));
      verbose = 1'b1;

      // reset mid-burst with output and skid occupied
      step(1'b1, four_sat, 1'b1, 1'b1, 1'b0);
      step(1'b1, rand_beat(), 1'b1, 1'b1, 1'b0);
      step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
      step(1'b1, rand_beat(), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 64'(n_if.out_valid), 64'(0));
      chk("midrst_in_ready", 64'(n_if.in_ready), 64'(0));
      chk("midrst_sat_count", 64'(n_if.sat_count), 64'(0));
      chk("midrst_out_sat", 64'(n_if.out_sat), 64'(0));
      rst = 1'b0;
      n_if.in_valid = 1'b0;
      clear_model();
      for (int i = 0; i < 30; i++) begin
         step($urandom_range(0, 3) != 0, rand_beat(), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
